// File: rtl/trigger_capture_buffer.sv
// trigger_capture_buffer: circular two-channel sample memory frozen around a level-crossing trigger
module trigger_capture_buffer #(
  parameter int SAMPLE_BITS        = 12,
  parameter int ADDRESS_BITS       = 10,
  parameter int PRETRIGGER_SAMPLES = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [SAMPLE_BITS-1:0]  channel1,
  input  logic signed [SAMPLE_BITS-1:0]  channel2,
  input  logic                           channelDataReady,
  input  logic                           arm,
  input  logic signed [SAMPLE_BITS-1:0]  triggerLevel,
  input  logic                           triggerRising,
  input  logic                           triggerSource,
  input  logic        [ADDRESS_BITS-1:0] readAddress,
  output logic signed [SAMPLE_BITS-1:0]  readChannel1,
  output logic signed [SAMPLE_BITS-1:0]  readChannel2,
  output logic                           captureDone,
  output logic        [1:0]              state
);
  localparam int DEPTH = 1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS-1:0] PRE_LEN   = ADDRESS_BITS'(PRETRIGGER_SAMPLES);
  localparam logic [ADDRESS_BITS-1:0] PRE_LAST  = ADDRESS_BITS'(PRETRIGGER_SAMPLES - 1);
  localparam logic [ADDRESS_BITS-1:0] POST_LAST = ADDRESS_BITS'(DEPTH - PRETRIGGER_SAMPLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ARMED, S_POST} state_t;

  state_t                          r_state, w_next;
  logic [2*SAMPLE_BITS-1:0]        r_mem [DEPTH];
  logic [ADDRESS_BITS-1:0]         r_wp, r_start, r_pre_cnt, r_post_cnt;
  logic signed [SAMPLE_BITS-1:0]   r_prev, r_level, r_rd1, r_rd2;
  logic                            r_rising, r_source, r_done;
  logic                            w_we, w_hit;
  logic signed [SAMPLE_BITS-1:0]   w_cur;
  logic [ADDRESS_BITS-1:0]         w_raddr;
  logic [2*SAMPLE_BITS-1:0]        w_rword;

  assign w_we    = channelDataReady && (r_state != S_IDLE);
  assign w_cur   = r_source ? channel2 : channel1;
  assign w_hit   = r_rising ? (r_prev < r_level && w_cur >= r_level)
                            : (r_prev > r_level && w_cur <= r_level);
  assign w_raddr = r_start + readAddress;
  assign w_rword = r_mem[w_raddr];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = arm ? S_PRE : S_IDLE;
      S_PRE:   w_next = (w_we && r_pre_cnt == PRE_LAST) ? S_ARMED : S_PRE;
      S_ARMED: w_next = (w_we && w_hit) ? S_POST : S_ARMED;
      default: w_next = (w_we && r_post_cnt == POST_LAST) ? S_IDLE : S_POST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // memory is deliberately left out of reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (!reset && w_we) r_mem[r_wp] <= {channel1, channel2};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp       <= '0;
      r_start    <= '0;
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
      r_prev     <= '0;
      r_level    <= '0;
      r_rising   <= 1'b0;
      r_source   <= 1'b0;
      r_done     <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
    end else begin
      r_rd1 <= w_rword[2*SAMPLE_BITS-1:SAMPLE_BITS];
      r_rd2 <= w_rword[SAMPLE_BITS-1:0];
      if (r_state == S_IDLE && arm) begin
        r_done    <= 1'b0;
        r_pre_cnt <= '0;
        r_level   <= triggerLevel;
        r_rising  <= triggerRising;
        r_source  <= triggerSource;
      end
      if (w_we) begin
        r_wp   <= r_wp + 1'b1;
        r_prev <= w_cur;
        if (r_state == S_PRE) r_pre_cnt <= r_pre_cnt + 1'b1;
        if (r_state == S_ARMED && w_hit) begin
          r_start    <= r_wp - PRE_LEN;
          r_post_cnt <= '0;
        end
        if (r_state == S_POST) r_post_cnt <= r_post_cnt + 1'b1;
        if (r_state == S_POST && r_post_cnt == POST_LAST) r_done <= 1'b1;
      end
    end
  end

  assign readChannel1 = r_rd1;
  assign readChannel2 = r_rd2;
  assign captureDone  = r_done;
  assign state        = r_state;
endmodule

// File: tb/tb_trigger_capture_buffer.sv
// tb_trigger_capture_buffer: directed self-checking bench, DEPTH=16 with 4 pre-trigger samples
module tb_trigger_capture_buffer;
  localparam int SB = 12;
  localparam int AB = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic signed [SB-1:0] channel1 = '0, channel2 = '0, triggerLevel = '0;
  logic                 channelDataReady = 1'b0, arm = 1'b0;
  logic                 triggerRising = 1'b1, triggerSource = 1'b0;
  logic        [AB-1:0] readAddress = '0;
  logic signed [SB-1:0] readChannel1, readChannel2;
  logic                 captureDone;
  logic        [1:0]    state;

  int passed = 0;
  int total  = 0;

  trigger_capture_buffer #(.SAMPLE_BITS(SB), .ADDRESS_BITS(AB), .PRETRIGGER_SAMPLES(4)) dut (
    .clock(clock), .reset(reset), .channel1(channel1), .channel2(channel2),
    .channelDataReady(channelDataReady), .arm(arm), .triggerLevel(triggerLevel),
    .triggerRising(triggerRising), .triggerSource(triggerSource), .readAddress(readAddress),
    .readChannel1(readChannel1), .readChannel2(readChannel2), .captureDone(captureDone),
    .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic send(input int c1, input int c2);
    channel1 = SB'(c1);
    channel2 = SB'(c2);
    channelDataReady = 1'b1;
    @(negedge clock);
    channelDataReady = 1'b0;
  endtask

  task automatic do_arm(input int level, input logic rising, input logic src);
    triggerLevel  = SB'(level);
    triggerRising = rising;
    triggerSource = src;
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  task automatic rd(input string tag, input int addr, input int e1, input int e2);
    readAddress = AB'(addr);
    @(negedge clock);
    check({tag, "_ch1"}, readChannel1, e1);
    check({tag, "_ch2"}, readChannel2, e2);
  endtask

  initial begin
    readAddress = 4'd3;
    repeat (2) @(negedge clock);
    check("reset_state", state, 0);
    check("reset_done", captureDone, 0);
    check("reset_rd1", readChannel1, 0);
    reset = 1'b0;
    @(negedge clock);

    // rising trigger on channel1, level 50, samples 10*k back-to-back
    do_arm(50, 1'b1, 1'b0);
    check("arm_state", state, 1);
    for (int k = 0; k < 17; k++) begin
      send(10 * k, -k);
      if (k == 2)  check("r_pre_k2", state, 1);
      if (k == 3)  check("r_armed_k3", state, 2);
      if (k == 4)  check("r_armed_k4", state, 2);
      if (k == 5)  check("r_post_k5", state, 3);
      if (k == 15) check("r_notdone_k15", captureDone, 0);
    end
    check("r_done", captureDone, 1);
    check("r_idle", state, 0);
    rd("r_a0", 0, 10, -1);
    rd("r_a4", 4, 50, -5);
    rd("r_a15", 15, 160, -16);

    // wrap-around: second capture starts with the write pointer at 1
    do_arm(51, 1'b1, 1'b0);
    check("w_done_cleared", captureDone, 0);
    for (int k = 0; k < 17; k++) begin
      send(10 * k + 1, 7);
      if (k == 5) check("w_post_k5", state, 3);
    end
    check("w_done", captureDone, 1);
    rd("w_a0", 0, 11, 7);
    rd("w_a4", 4, 51, 7);
    rd("w_a15", 15, 161, 7);

    // falling trigger on channel2, level -100
    do_arm(-100, 1'b0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      send(j, -30 * j);
      if (j == 3) check("f_armed_j3", state, 2);
      if (j == 4) check("f_post_j4", state, 3);
    end
    check("f_done", captureDone, 1);
    rd("f_a4", 4, 4, -120);
    rd("f_a0", 0, 0, 0);
    rd("f_a15", 15, 15, -450);

    // crossing inside pre-trigger window must not fire
    do_arm(20, 1'b1, 1'b0);
    send(0, 0); send(30, 0); send(30, 0); send(30, 0);
    check("p_armed", state, 2);
    send(0, 0);
    check("p_no_trig", state, 2);
    send(30, 0);
    check("p_trig", state, 3);
    for (int k = 0; k < 11; k++) send(40 + k, 0);
    check("p_done", captureDone, 1);
    rd("p_a0", 0, 30, 0);
    rd("p_a3", 3, 0, 0);
    rd("p_a4", 4, 30, 0);
    rd("p_a5", 5, 40, 0);

    // constant input never triggers; arm while armed is ignored
    do_arm(50, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) send(5, 5);
    check("n_armed", state, 2);
    check("n_notdone", captureDone, 0);
    do_arm(0, 1'b0, 1'b1);
    check("n_arm_ignored", state, 2);
    send(5, 5);
    check("n_still_armed", state, 2);
    send(60, -900);
    check("n_level_kept", state, 3);
    send(61, 0); send(62, 0);

    // reset mid-capture
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("x_state", state, 0);
    check("x_done", captureDone, 0);
    check("x_rd1", readChannel1, 0);
    check("x_rd2", readChannel2, 0);
    reset = 1'b0;
    @(negedge clock);
    check("x_idle_after", state, 0);

    // clean capture after reset; arm and strobe together writes nothing
    triggerLevel = 12'sd50; triggerRising = 1'b1; triggerSource = 1'b0;
    arm = 1'b1; channelDataReady = 1'b1; channel1 = 12'sd999; channel2 = 12'sd999;
    @(negedge clock);
    arm = 1'b0; channelDataReady = 1'b0;
    check("c_pre", state, 1);
    for (int k = 0; k < 17; k++) send(10 * k, 3);
    check("c_done", captureDone, 1);
    rd("c_a0", 0, 10, 3);
    rd("c_a15", 15, 160, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trigger_capture_buffer.md
# trigger_capture_buffer

Triggered two-channel sample capture memory for the oscilloscope datapath. It sits directly downstream of the XADC channel reader. On each `channelDataReady` pulse it writes the paired channel1/channel2 sample into a circular buffer, and detects a level-crossing trigger on the selected channel. It freezes a window of pre-trigger and post-trigger samples that the display stage reads back through a registered, trigger-aligned read port.

## Interface
Parameters:
- SAMPLE_BITS, 12, signed sample width per channel
- ADDRESS_BITS, 10, buffer address width; DEPTH = 2^ADDRESS_BITS sample pairs
- PRETRIGGER_SAMPLES, 256, samples kept before the trigger sample; legal range 1 .. DEPTH-2

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- channel1  in  SAMPLE_BITS  signed sample, valid with channelDataReady
- channel2  in  SAMPLE_BITS  signed sample, valid with channelDataReady
- channelDataReady  in  1  one-cycle strobe: new sample pair present
- arm  in  1  one-cycle request to start a capture
- triggerLevel  in  SAMPLE_BITS  signed trigger threshold
- triggerRising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- triggerSource  in  1  0 = channel1, 1 = channel2
- readAddress  in  ADDRESS_BITS  capture-relative index; 0 = oldest sample of the window
- readChannel1  out  SAMPLE_BITS  channel1 sample at readAddress
- readChannel2  out  SAMPLE_BITS  channel2 sample at readAddress
- captureDone  out  1  level; high while a complete capture is held
- state  out  2  FSM state, for debug

## Operation
- States: IDLE=00, PRETRIGGER=01, ARMED=10, POSTTRIGGER=11.
- **IDLE:** no writes. `arm` does the following, then moves to PRETRIGGER:
  - clears captureDone and preCount;
  - registers triggerLevel, triggerRising and triggerSource, which are held constant until the next arm.
- `arm` is ignored outside IDLE.
- **Sample write:** in PRETRIGGER, ARMED and POSTTRIGGER, every channelDataReady does the following:
  - writes {channel1, channel2} at writePointer;
  - increments writePointer modulo DEPTH (wraps naturally);
  - updates previousSample with the selected source channel value.
- **PRETRIGGER:** counts written samples. On the write that makes the count equal PRETRIGGER_SAMPLES, move to ARMED. Trigger crossings are ignored in this state.
- **ARMED:** on each written sample, compare against previousSample (prev) and the registered level. All comparisons are signed, full SAMPLE_BITS.
  - Rising: prev < level AND cur >= level.
  - Falling: prev > level AND cur <= level.
- **On trigger:**
  - triggerAddress = address just written;
  - startAddress = triggerAddress - PRETRIGGER_SAMPLES mod DEPTH;
  - postCount = 0;
  - move to POSTTRIGGER.
- **POSTTRIGGER:** collects DEPTH-PRETRIGGER_SAMPLES-1 further samples. On the write that completes the count, move to IDLE and set captureDone.
- Without a trigger, ARMED persists indefinitely and the buffer keeps overwriting.
- **Read:**
  - physical address = startAddress + readAddress mod DEPTH;
  - data is registered onto readChannel1/readChannel2;
  - reads are valid only while captureDone = 1; otherwise the data is don't-care but stable-clocked.
- **Reset, any state including mid-capture:**
  - state = IDLE; captureDone = 0;
  - writePointer, startAddress, triggerAddress, counters and previousSample = 0;
  - readChannel1 and readChannel2 = 0.
  - Memory contents are not cleared.

## Timing
- A write happens on the clock edge where channelDataReady is high. Back-to-back strobes (every cycle) are supported with no loss.
- State and counter updates happen on the same edge as the write. A new state is visible the cycle after the qualifying strobe.
- captureDone rises the cycle after the final post-trigger strobe, together with state = IDLE.
- If arm and channelDataReady arrive in the same IDLE cycle, that sample is not written. The first written sample is the next strobe.
- Trigger detection is combinational on the incoming sample against registered prev. There is no added sample latency; the trigger sample itself is the write at triggerAddress.
- Read latency is 1 cycle: readAddress applied at edge N appears on the outputs after edge N+1.
- Reset has priority over arm and channelDataReady in the same cycle.

## Test plan
Parameters for all scenarios: ADDRESS_BITS=4 (DEPTH=16), PRETRIGGER_SAMPLES=4.

- **Reset:** assert reset 2 cycles mid-POSTTRIGGER -> state=00, captureDone=0, readChannel1=readChannel2=0, next arm starts cleanly.
- **Rising trigger, channel1:** level=50, arm, channel1 = 10*k for k=0.. -> trigger at k=5; captureDone one cycle after k=16 strobe; readAddress 0 -> 10, 4 -> 50, 15 -> 160, each 1 cycle after address.
- **Falling trigger, channel2:** level=-100, channel2 = 0, -30, -60, ... -> trigger on -120 (prev -90); readAddress 4 returns -120 on readChannel2; channel1 data is stored alongside it.
- **Crossing inside PRETRIGGER is ignored:** rising level=20, channel1 = 0, 30, 30, 30, 0, 30 -> no trigger during the first 4 samples; trigger on the 6th sample (0 -> 30).
- **No trigger and arm ignored:** constant input of 5, level=50 -> stays ARMED for 100 strobes with captureDone=0; an arm pulse while ARMED changes nothing.
- **Wrap-around:** a second capture immediately after scenario 2 -> startAddress is non-zero, readAddress 0 still returns the oldest pre-trigger sample, and captureDone is cleared by the arm.
